// File: rtl/rx_byte_packer.sv
// rx_byte_packer: packs a byte stream (valid/ready/last) into OUT_WIDTH-bit
// words, little-endian by lane, and buffers them in a small first-word-fall-through
// FIFO that feeds the wide RX datapath.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   in_data/in_valid/in_last/in_ready    - byte-wide input handshake
//   out_data/out_keep/out_last/out_valid/out_ready - word-wide output handshake
//   almost_full       - FIFO occupancy >= ALMOST_FULL_NUM
//   word_count        - FIFO occupancy, 0..2^DEPTH_WIDTH
module rx_byte_packer #(
    parameter int unsigned IN_WIDTH        = 8,
    parameter int unsigned OUT_WIDTH       = 128,
    parameter int unsigned DEPTH_WIDTH     = 2,
    parameter int unsigned ALMOST_FULL_NUM = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IN_WIDTH-1:0]               in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic [OUT_WIDTH/IN_WIDTH-1:0]     out_keep,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              almost_full,
    output logic [DEPTH_WIDTH:0]              word_count
);

    localparam int unsigned LANES = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned IDX_W = $clog2(LANES);
    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam int unsigned PTR_W = DEPTH_WIDTH + 1;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [LANES-1:0]     keep;
        logic                 last;
    } word_t;

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] asm_q, asm_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 almost_full_q, almost_full_d;
    logic                 full_d, empty_d;
    word_t                mem_q [DEPTH];
    word_t                push_word;
    word_t                head;
    logic                 accept, commit, pop;

    // Lane assembly: merge the incoming byte into its lane and decide commit
    always_comb begin
        accept         = in_valid && in_ready_q;
        commit         = accept && (in_last || (idx_q == IDX_W'(LANES - 1)));
        push_word.data = asm_q;
        push_word.keep = '0;
        push_word.last = in_last;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                push_word.data[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
            push_word.keep[i] = (IDX_W'(i) <= idx_q);
        end

        asm_d = asm_q;
        idx_d = idx_q;
        if (commit) begin
            asm_d = '0;
            idx_d = '0;
        end else if (accept) begin
            asm_d = push_word.data;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // FIFO pointer/flag next state; flags are registered so in_ready has no
    // combinational path from out_ready
    always_comb begin
        pop           = out_valid_q && out_ready;
        wr_ptr_d      = wr_ptr_q + PTR_W'(commit);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        count_d       = wr_ptr_d - rd_ptr_d;
        empty_d       = (wr_ptr_d == rd_ptr_d);
        full_d        = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                        (wr_ptr_d[PTR_W-2:0] == rd_ptr_d[PTR_W-2:0]);
        in_ready_d    = !full_d;
        out_valid_d   = !empty_d;
        almost_full_d = (count_d >= PTR_W'(ALMOST_FULL_NUM));
    end

    // Control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q         <= '0;
            asm_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            asm_q         <= asm_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Word storage; cleared on reset so the head reads as zero when empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= push_word;
        end
    end

    assign head        = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
    assign out_data    = head.data;
    assign out_keep    = head.keep;
    assign out_last    = head.last;
    assign out_valid   = out_valid_q;
    assign in_ready    = in_ready_q;
    assign almost_full = almost_full_q;
    assign word_count  = count_q;

endmodule

// File: tb/tb_rx_byte_packer.sv
// Testbench for rx_byte_packer: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a queue-based model.
module tb_rx_byte_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] out_data;
    logic [15:0]  out_keep;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         almost_full;
    logic [2:0]   word_count;

    always #5 clk = ~clk;

    rx_byte_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .almost_full(almost_full),
        .word_count (word_count)
    );

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } word_t;

    typedef struct {
        logic [7:0]   d;
        logic         v;
        logic         l;
        logic         r;
        logic         ev;
        logic [2:0]   ec;
        logic [127:0] ed;
        logic [15:0]  ek;
        logic         el;
    } vec_t;

    word_t      mq[$];   // words the model says are buffered, head first
    logic [7:0] pb[$];   // bytes of the word being assembled
    int         errors = 0;
    int         checks = 0;
    logic       m_acc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: update the model from the driven inputs, then compare outputs
    task automatic step();
        logic  rdy_pred, pop_now;
        word_t w, dummy;
        int    n;
        @(posedge clk);
        m_acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            pb.delete();
        end else begin
            rdy_pred = (mq.size() < 4);
            pop_now  = (mq.size() != 0) && out_ready;
            m_acc    = in_valid && rdy_pred;
            if (pop_now) dummy = mq.pop_front();
            if (m_acc) begin
                pb.push_back(in_data);
                if (pb.size() == 16 || in_last) begin
                    n      = pb.size();
                    w.data = '0;
                    for (int i = 0; i < n; i++) w.data[8*i +: 8] = pb[i];
                    w.keep = 16'((32'd1 << n) - 32'd1);
                    w.last = in_last;
                    mq.push_back(w);
                    pb.delete();
                end
            end
        end
        #1;
        chk("out_valid",   128'(out_valid),   128'(mq.size() != 0));
        chk("word_count",  128'(word_count),  128'(mq.size()));
        chk("in_ready",    128'(in_ready),    128'(mq.size() < 4));
        chk("almost_full", 128'(almost_full), 128'(mq.size() >= 3));
        if (mq.size() != 0) begin
            chk("out_data", out_data,          mq[0].data);
            chk("out_keep", 128'(out_keep),    128'(mq[0].keep));
            chk("out_last", 128'(out_last),    128'(mq[0].last));
        end
    endtask

    // Offer n bytes base, base+1, ... holding each until accepted
    task automatic send(input int n, input logic [7:0] base, input bit last_at_end);
        int sent   = 0;
        int budget = 0;
        while (sent < n) begin
            in_data  = base + 8'(sent);
            in_valid = 1'b1;
            in_last  = last_at_end && (sent == n - 1);
            step();
            if (m_acc) sent++;
            budget++;
            if (budget > 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got %0d bytes accepted expected %0d", sent, n);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (mq.size() != 0 && budget < 20) begin
            step();
            budget++;
        end
        step();
        out_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic l, input logic r,
                                input logic ev, input logic [2:0] ec, input logic [127:0] ed,
                                input logic [15:0] ek, input logic el);
        vec_t t;
        t.d = d; t.v = v; t.l = l; t.r = r;
        t.ev = ev; t.ec = ec; t.ed = ed; t.ek = ek; t.el = el;
        return t;
    endfunction

    vec_t tv[23];

    initial begin
        logic [127:0] exp_word;
        int           k;
        int           budget;

        // Full 16-byte word, short packet, then a 1-byte packet at lane 0
        for (int i = 0; i < 15; i++) tv[i] = mk(8'(i), 1, 0, 1, 0, 3'd0, '0, '0, 0);
        tv[15] = mk(8'h0F, 1, 0, 1, 1, 3'd1, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 0);
        tv[16] = mk(8'h00, 0, 0, 1, 0, 3'd0, '0, '0, 0);
        tv[17] = mk(8'hA1, 1, 0, 1, 0, 3'd0, '0, '0, 0);
        tv[18] = mk(8'hB2, 1, 0, 1, 0, 3'd0, '0, '0, 0);
        tv[19] = mk(8'hC3, 1, 1, 1, 1, 3'd1, 128'h0000000000000000000000_00C3B2A1, 16'h0007, 1);
        tv[20] = mk(8'h00, 0, 0, 1, 0, 3'd0, '0, '0, 0);
        tv[21] = mk(8'h55, 1, 1, 1, 1, 3'd1, 128'h55, 16'h0001, 1);
        tv[22] = mk(8'h00, 0, 0, 1, 0, 3'd0, '0, '0, 0);

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (5) step();
        chk("rst_out_data", out_data,         '0);
        chk("rst_out_keep", 128'(out_keep),   '0);
        chk("rst_out_last", 128'(out_last),   '0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            in_data   = tv[i].d;
            in_valid  = tv[i].v;
            in_last   = tv[i].l;
            out_ready = tv[i].r;
            step();
            chk("tv_valid", 128'(out_valid),  128'(tv[i].ev));
            chk("tv_count", 128'(word_count), 128'(tv[i].ec));
            if (tv[i].ev) begin
                chk("tv_data", out_data,         tv[i].ed);
                chk("tv_keep", 128'(out_keep),   128'(tv[i].ek));
                chk("tv_last", 128'(out_last),   128'(tv[i].el));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Backpressure: fill the FIFO, hold byte 65, release one word
        k      = 0;
        budget = 0;
        while (k < 64 && budget < 300) begin
            in_data  = 8'(k);
            in_valid = 1'b1;
            step();
            if (m_acc) begin
                k++;
                if (k == 48) begin
                    chk("bp_count3", 128'(word_count), 128'd3);
                    chk("bp_af3",    128'(almost_full), 128'd1);
                end
            end
            budget++;
        end
        chk("bp_count4",    128'(word_count), 128'd4);
        chk("bp_ready_low", 128'(in_ready),   128'd0);
        in_data = 8'd64;
        repeat (3) step();
        chk("bp_held_count", 128'(word_count), 128'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_pop_count", 128'(word_count), 128'd3);
        chk("bp_ready_up",  128'(in_ready),   128'd1);
        send(16, 8'd64, 0);
        chk("bp_refill", 128'(word_count), 128'd4);
        out_ready = 1'b1;
        repeat (3) step();
        chk("bp_lane0",  128'(out_data[7:0]), 128'h40);
        chk("bp_keep5",  128'(out_keep),      128'hFFFF);
        drain();

        // Commit coinciding with a pop at occupancy 2
        send(32, 8'h10, 0);
        send(15, 8'h70, 0);
        in_data   = 8'h7F;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", 128'(word_count), 128'd2);
        chk("pp_head",  128'(out_data[7:0]), 128'h20);
        drain();

        // in_last on lane 15: one full word, no extra empty word
        send(16, 8'h30, 1);
        chk("bl_count", 128'(word_count), 128'd1);
        chk("bl_keep",  128'(out_keep),   128'hFFFF);
        chk("bl_last",  128'(out_last),   128'd1);
        repeat (2) step();
        chk("bl_no_extra", 128'(word_count), 128'd1);
        drain();

        // Reset with a partial word and two buffered words
        send(39, 8'h80, 0);
        chk("rm_count2", 128'(word_count), 128'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rm_valid", 128'(out_valid),  128'd0);
        chk("rm_count", 128'(word_count), 128'd0);
        chk("rm_data",  out_data,         '0);
        send(16, 8'hC0, 0);
        exp_word = '0;
        for (int i = 0; i < 16; i++) exp_word[8*i +: 8] = 8'hC0 + 8'(i);
        chk("rm_clean_data", out_data,        exp_word);
        chk("rm_clean_keep", 128'(out_keep),  128'hFFFF);
        drain();

        // Randomized traffic with bursts of downstream stall
        for (int c = 0; c < 3000; c++) begin
            if (!(in_valid && !m_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_last  = ($urandom_range(0, 7) == 0);
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < (((c / 200) % 2) != 0 ? 85 : 25));
            step();
        end
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_byte_packer.md
Name: rx_byte_packer

Overview:
- Receive-side width converter, the reverse of the 128-bit-in / 8-bit-out TX FIFO path.
- Accepts a byte stream with valid/ready/last and packs every 16 bytes into one 128-bit word.
- Buffers packed words in a small internal first-word-fall-through FIFO.
- Presents words with a per-byte keep mask and last flag to the wide RX datapath on a valid/ready handshake.

Parameters:
- IN_WIDTH, 8, input byte width; fixed at 8.
- OUT_WIDTH, 128, output word width; must be a multiple of IN_WIDTH. LANES = OUT_WIDTH/IN_WIDTH = 16.
- DEPTH_WIDTH, 2, log2 of output FIFO depth; default depth 4 words.
- ALMOST_FULL_NUM, 3, almost_full asserts when occupancy >= this value.

Ports:
- clk, input, 1: sole clock.
- rst_n, input, 1: reset, synchronous, active-low.
- in_data, input, 8: input byte.
- in_valid, input, 1: in_data is valid.
- in_last, input, 1: current byte ends a packet.
- in_ready, output, 1: block can accept a byte this cycle.
- out_data, output, 128: packed word at the FIFO head.
- out_keep, output, 16: valid-byte mask for out_data; bit i covers out_data[8i+7:8i].
- out_last, output, 1: word ends a packet.
- out_valid, output, 1: out_data/out_keep/out_last are valid.
- out_ready, input, 1: downstream takes the word.
- almost_full, output, 1: FIFO occupancy >= ALMOST_FULL_NUM.
- word_count, output, DEPTH_WIDTH+1: FIFO occupancy, 0..2^DEPTH_WIDTH.

Behaviour:
- Reset (rst_n low at posedge clk) sets:
  - lane index = 0, assembly register = 0, FIFO pointers = 0, word_count = 0.
  - out_valid = 0, out_data = 0, out_keep = 0, out_last = 0, almost_full = 0.
  - in_ready = 1 from the first cycle after reset release.
- Reset mid-operation discards any partial word and all buffered words. No output is produced for them.
- Byte accept: in_valid && in_ready at posedge. The byte is written into lane idx, i.e. bits [8*idx+7:8*idx]. The first byte of a word lands in lane 0 (little-endian).
- After an accepted byte, idx increments by 1 unless the byte commits the word.
- Commit condition: an accepted byte with idx == 15 or in_last == 1.
- On commit:
  - Push {data, keep, last} into the FIFO. keep = lanes 0..idx set. last = in_last.
  - Lanes above idx in the pushed word read as 0.
  - idx returns to 0 and the assembly register clears.
- in_last on lane 15 produces a single word with keep = 16'hFFFF and last = 1. No extra empty word is generated.
- in_ready = !(word_count == 2^DEPTH_WIDTH). It is registered-state derived, with no combinational path from out_ready.
- While in_ready is low, in_valid is ignored and the byte is not consumed. The source must hold it.
- The block never overflows.
- Latency: the committing byte accepted at edge N gives out_valid = 1 after edge N when the FIFO was empty. The word is visible in the cycle following the commit.
- Output handshake:
  - out_valid = (word_count != 0). FIFO is first-word-fall-through; out_data/keep/last show the head.
  - A pop occurs on out_valid && out_ready. The next head appears the following cycle.
  - out_data/keep/last stay stable while out_valid && !out_ready.
- Simultaneous push and pop: word_count unchanged; both pointers advance.
- Push when full: impossible, because in_ready is low.
- Pop when full: word_count becomes depth-1 and in_ready rises the following cycle.
- Pointers are DEPTH_WIDTH+1 bits and wrap modulo 2^(DEPTH_WIDTH+1). Full/empty are decided by MSB compare.
- almost_full and word_count are updated on the same edge as the pointers.

Test Plan:
- Full-word pack:
  - Stimulus: rst_n low 5 cycles, then bytes 0x00..0x0F back-to-back, in_last = 0, out_ready = 1.
  - Required: exactly one word, out_data = 128'h0F0E0D0C0B0A09080706050403020100, out_keep = 16'hFFFF, out_last = 0.
  - Required: out_valid rises the cycle after byte 0x0F is accepted.
- Short packet:
  - Stimulus: bytes 0xA1, 0xB2, 0xC3 with in_last on 0xC3.
  - Required: out_data = 128'h...00C3B2A1 with upper 104 bits 0, out_keep = 16'h0007, out_last = 1.
  - Required: next packet starts at lane 0.
- Backpressure/full:
  - Stimulus: out_ready = 0, continuous 80-byte stream.
  - Required: word_count reaches 4 and almost_full = 1 at count 3. in_ready = 0 after the 64th byte; byte 65 is held, not lost.
  - Then out_ready = 1 for one cycle: word_count = 3, in_ready returns high, byte 65 accepted into lane 0.
- Concurrent push/pop at occupancy 2:
  - Stimulus: a commit coinciding with a pop.
  - Required: word_count stays 2, order preserved.
  - Required: 12 words through the depth-4 FIFO, spanning pointer wrap, emerge in order with correct data.
- Boundary last:
  - Stimulus: in_last asserted on the 16th byte.
  - Required: one word, keep = 16'hFFFF, last = 1, no extra word.
- Reset mid-word:
  - Stimulus: 7 bytes accepted plus 2 buffered words, then rst_n low 1 cycle.
  - Required: out_valid = 0 and word_count = 0 after reset.
  - Required: the next 16 bytes form a clean word starting at lane 0.
